// File: rtl/viterbi_pkg.sv
// Shared definitions for the Viterbi decoder self-test controller:
// FSM encoding, default frame geometry and index-width helper.
package viterbi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam int SYM_W_DEF = 2;
  localparam int N_SYM_DEF = 544;
  localparam int N_BIT_DEF = 512;

  // Bits needed to hold every value 0..max_val inclusive.
  function automatic int idx_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/viterbi_bist_checker.sv
// Output-side checker: walks the golden ROM, compares decoded bits,
// keeps saturating correct/error counters and the first mismatch index.
module viterbi_bist_checker
  import viterbi_pkg::*;
#(
  parameter int N_BIT = N_BIT_DEF,
  parameter int GA_W  = 9,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             RSTn,
  input  logic             clear,
  input  logic             active,
  input  logic             d_out_valid,
  input  logic             d_out,
  input  logic             gold_data,
  output logic [GA_W-1:0]  gold_addr,
  output logic [CNT_W-1:0] correct_cnt,
  output logic [CNT_W-1:0] error_cnt,
  output logic [GA_W-1:0]  first_err_idx,
  output logic             out_done,
  output logic             result_ok
);

  localparam int OW = idx_w(N_BIT);

  logic [OW-1:0]    out_idx_r;
  logic [OW-1:0]    out_idx_nxt_s;
  logic [CNT_W-1:0] corr_nxt_s;
  logic [CNT_W-1:0] err_nxt_s;
  logic [GA_W-1:0]  first_nxt_s;
  logic             seen_r;
  logic             seen_nxt_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Next-state of the compare path; the gold ROM is addressed with it so
  // gold_data always lines up with the registered out_idx.
  always_comb begin
    out_idx_nxt_s = out_idx_r;
    corr_nxt_s    = correct_cnt;
    err_nxt_s     = error_cnt;
    first_nxt_s   = first_err_idx;
    seen_nxt_s    = seen_r;
    if (clear) begin
      out_idx_nxt_s = '0;
      corr_nxt_s    = '0;
      err_nxt_s     = '0;
      first_nxt_s   = '1;
      seen_nxt_s    = 1'b0;
    end else if (active && d_out_valid) begin
      if (out_idx_r < OW'(N_BIT)) begin
        out_idx_nxt_s = out_idx_r + OW'(1);
        if (d_out == gold_data) begin
          corr_nxt_s = sat_inc(correct_cnt);
        end else begin
          err_nxt_s = sat_inc(error_cnt);
          if (!seen_r) begin
            first_nxt_s = GA_W'(out_idx_r);
            seen_nxt_s  = 1'b1;
          end else begin
            first_nxt_s = first_err_idx;
          end
        end
      end else begin
        // excess output beyond the frame: index saturates, bit is an error
        err_nxt_s = sat_inc(error_cnt);
      end
    end else begin
      out_idx_nxt_s = out_idx_r;
    end
  end

  assign gold_addr = GA_W'(out_idx_nxt_s);
  assign out_done  = (out_idx_r == OW'(N_BIT));
  assign result_ok = (err_nxt_s == '0) && (corr_nxt_s == CNT_W'(N_BIT));

  // Checker state registers.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      out_idx_r     <= '0;
      correct_cnt   <= '0;
      error_cnt     <= '0;
      first_err_idx <= '1;
      seen_r        <= 1'b0;
    end else begin
      out_idx_r     <= out_idx_nxt_s;
      correct_cnt   <= corr_nxt_s;
      error_cnt     <= err_nxt_s;
      first_err_idx <= first_nxt_s;
      seen_r        <= seen_nxt_s;
    end
  end

endmodule

// File: rtl/viterbi_bist_ctrl.sv
// Self-test controller for the Viterbi decoder: streams stimulus ROM symbols
// with a programmable gap, then waits (with watchdog) for the checker to finish.
module viterbi_bist_ctrl
  import viterbi_pkg::*;
#(
  parameter int SYM_W   = SYM_W_DEF,
  parameter int N_SYM   = N_SYM_DEF,
  parameter int N_BIT   = N_BIT_DEF,
  parameter int SA_W    = 10,
  parameter int GA_W    = 9,
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             RSTn,
  input  logic             start,
  input  logic [3:0]       gap_cfg,
  output logic [SA_W-1:0]  stim_addr,
  input  logic [SYM_W-1:0] stim_data,
  output logic [GA_W-1:0]  gold_addr,
  input  logic             gold_data,
  output logic             d_in_valid,
  output logic [SYM_W-1:0] d_in,
  input  logic             d_out_valid,
  input  logic             d_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [CNT_W-1:0] correct_cnt,
  output logic [CNT_W-1:0] error_cnt,
  output logic [GA_W-1:0]  first_err_idx
);

  localparam int IW = idx_w(N_SYM);
  localparam int WW = idx_w(TIMEOUT);

  state_e         state_r;
  logic [IW-1:0]  in_idx_r;
  logic [IW-1:0]  in_idx_nxt_s;
  logic [3:0]     gap_r;
  logic [WW-1:0]  wd_r;
  logic           launch_s;
  logic           issue_s;
  logic           chk_active_s;
  logic           out_done_s;
  logic           result_ok_s;

  assign launch_s     = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
  assign issue_s      = (state_r == ST_RUN) && (gap_r == 4'd0);
  assign chk_active_s = (state_r == ST_LOAD) || (state_r == ST_RUN) || (state_r == ST_DRAIN);

  // Look-ahead stimulus index so the registered ROM presents ROM[in_idx].
  always_comb begin
    in_idx_nxt_s = in_idx_r;
    if (launch_s) begin
      in_idx_nxt_s = '0;
    end else if (issue_s) begin
      in_idx_nxt_s = in_idx_r + IW'(1);
    end else begin
      in_idx_nxt_s = in_idx_r;
    end
  end

  assign stim_addr = SA_W'(in_idx_nxt_s);

  // Run sequencing, symbol issue, drain watchdog and status flags.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      state_r    <= ST_IDLE;
      in_idx_r   <= '0;
      gap_r      <= 4'd0;
      wd_r       <= '0;
      d_in_valid <= 1'b0;
      d_in       <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      in_idx_r <= in_idx_nxt_s;
      case (state_r)
        ST_IDLE, ST_DONE: begin
          d_in_valid <= 1'b0;
          if (start) begin
            state_r <= ST_LOAD;
            gap_r   <= 4'd0;
            wd_r    <= '0;
            busy    <= 1'b1;
            done    <= 1'b0;
            pass    <= 1'b0;
            timeout <= 1'b0;
          end
        end
        ST_LOAD: begin
          state_r <= ST_RUN;
        end
        ST_RUN: begin
          if (issue_s) begin
            d_in_valid <= 1'b1;
            d_in       <= stim_data;
            gap_r      <= gap_cfg;
            if (in_idx_r == IW'(N_SYM - 1)) begin
              state_r <= ST_DRAIN;
              wd_r    <= '0;
            end
          end else begin
            d_in_valid <= 1'b0;
            gap_r      <= gap_r - 4'd1;
          end
        end
        ST_DRAIN: begin
          d_in_valid <= 1'b0;
          if (out_done_s) begin
            state_r <= ST_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            pass    <= result_ok_s;
          end else if (wd_r == WW'(TIMEOUT - 1)) begin
            state_r <= ST_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            pass    <= 1'b0;
            timeout <= 1'b1;
          end else begin
            wd_r <= wd_r + WW'(1);
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          d_in_valid <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

  viterbi_bist_checker #(
    .N_BIT (N_BIT),
    .GA_W  (GA_W),
    .CNT_W (CNT_W)
  ) u_checker (
    .clk           (clk),
    .RSTn          (RSTn),
    .clear         (launch_s),
    .active        (chk_active_s),
    .d_out_valid   (d_out_valid),
    .d_out         (d_out),
    .gold_data     (gold_data),
    .gold_addr     (gold_addr),
    .correct_cnt   (correct_cnt),
    .error_cnt     (error_cnt),
    .first_err_idx (first_err_idx),
    .out_done      (out_done_s),
    .result_ok     (result_ok_s)
  );

endmodule
